genc: RTL and testbench
=======================

GENC -- requirements
Module: genc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address loaded into pc on reset.
REQ-002 Parameter DMEM_WORDS, default 64, depth of internal 32-bit data memory (power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 komut  input  32  instruction at address pc, fetched combinationally from external instruction memory.
REQ-006 pc  output  32  registered program counter, byte address, always word-aligned.
REQ-007 hata  output  1  registered, sticky error flag.

Function
REQ-008 Single-cycle core: decode, execute and memory access for komut complete in one cycle; pc and all architectural state update on the same rising edge.
REQ-009 ISA is the RV32I encoding subset: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
REQ-010 Register file: 32 x 32 bits; x0 reads 0; writes to x0 discarded; two combinational reads, one write per cycle.
REQ-011 Immediates sign-extended per RV32I format; shift amounts use low 5 bits; arithmetic wraps modulo 2^32 with no overflow flag.
REQ-012 Next pc: pc+4 by default; branch taken -> pc+immB; JAL -> pc+immJ; JALR -> (rs1+immI) with bit 0 cleared; JAL/JALR write pc+4 to rd.
REQ-013 Data memory internal, word-addressed by address bits [log2(DMEM_WORDS)+1:2]; upper bits ignored (wrap-around); LW reads combinationally; SW writes on rising edge.
REQ-014 Illegal instruction: unknown opcode or funct3/funct7 combination, including all-zero word 32'h0000_0000.
REQ-015 Misaligned LW/SW address (bits [1:0] != 0) or jump/branch target with bits [1:0] != 0 is an error.
REQ-016 On an error condition at a rising edge: hata set to 1; no register, memory or pc update for that instruction.
REQ-017 While hata=1: core halted; pc holds; no register or memory writes; only reset clears hata.
REQ-018 Same-cycle read and write of one register: read returns old value; new value visible next cycle.

Reset
REQ-019 reset low: pc=RESET_PC, hata=0, all registers 0, all data memory words 0, immediately and independent of clk.
REQ-020 Reset asserted mid-instruction aborts it with no partial write; execution resumes from RESET_PC on the first rising edge after release.

Configuration
REQ-021 Macro GENC_MUL_EN defined: R-type opcode 0110011 with funct7=0000001 and funct3=000 executes MUL, rd = low 32 bits of rs1*rs2.
REQ-022 GENC_MUL_EN undefined: that encoding is illegal per REQ-014 and sets hata; no multiplier is synthesized.

Verification
REQ-023 Reset low 10 ns then high -> pc=0, hata=0; first rising edge with komut=ADDI x1,x0,5 -> x1=5, pc=4.
REQ-024 x1=5, x2=5, BEQ x1,x2,+8 at pc=8 -> pc=16; BNE with the same operands -> pc=12.
REQ-025 Iterative Fibonacci program computing F(20), 24 ns clock, 10 us run -> result register=6765, SW writes 6765 to data memory, hata=0.
REQ-026 komut=32'h0000_0000 at pc=20 -> hata=1 after the edge; pc remains 20; registers unchanged until reset low, which clears hata and sets pc=0.
REQ-027 SW x1,2(x0) -> hata=1, no memory write; LW from address 256 with DMEM_WORDS=64 -> reads word 0.
REQ-028 MUL x3,x1,x2 with x1=7, x2=6 -> x3=42 when GENC_MUL_EN is defined; hata=1 and x3 unchanged when it is not.

Source files
------------

// File: rtl/genc.sv
// +----------------------------------------------------------------------------+
// | Module  : genc                                                             |
// | Single-cycle RV32I-subset core with internal data memory, sticky error     |
// | halt. Define GENC_MUL_EN to add the MUL instruction.                       |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module genc #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] komut,
    output logic [31:0] pc,
    output logic        hata
);
    localparam int         c_AW        = $clog2(DMEM_WORDS);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    logic [31:0]     r_pc;
    logic            r_hata;
    logic [31:0]     r_regs [32];
    logic [31:0]     r_dmem [DMEM_WORDS];

    logic [6:0]      w_op;
    logic [6:0]      w_f7;
    logic [2:0]      w_f3;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic [31:0]     w_imm_i;
    logic [31:0]     w_imm_s;
    logic [31:0]     w_imm_b;
    logic [31:0]     w_imm_u;
    logic [31:0]     w_imm_j;
    logic [31:0]     w_addr;
    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_alu_b;
    logic            w_alu_alt;
    logic [31:0]     w_alu_y;
    logic [31:0]     w_wdata;
    logic [31:0]     w_next_pc;
    logic            w_legal;
    logic            w_wb;
    logic            w_store;
    logic            w_mem;
    logic            w_take;
    logic            w_err;
    logic            w_commit;
    logic            w_we_reg;
    logic            w_we_mem;
    logic            w_unused;

    assign pc   = r_pc;
    assign hata = r_hata;

    assign w_op  = komut[6:0];
    assign w_rd  = komut[11:7];
    assign w_f3  = komut[14:12];
    assign w_rs1 = komut[19:15];
    assign w_rs2 = komut[24:20];
    assign w_f7  = komut[31:25];

    assign w_imm_i = {{20{komut[31]}}, komut[31:20]};
    assign w_imm_s = {{20{komut[31]}}, komut[31:25], komut[11:7]};
    assign w_imm_b = {{19{komut[31]}}, komut[31], komut[7], komut[30:25], komut[11:8], 1'b0};
    assign w_imm_u = {komut[31:12], 12'h000};
    assign w_imm_j = {{11{komut[31]}}, komut[31], komut[19:12], komut[20], komut[30:21], 1'b0};

    assign w_a = (w_rs1 == 5'd0) ? 32'h0 : r_regs[w_rs1];
    assign w_b = (w_rs2 == 5'd0) ? 32'h0 : r_regs[w_rs2];

    // Upper address bits are deliberately dropped so accesses wrap around the memory.
    assign w_addr   = w_a + ((w_op == c_OP_STORE) ? w_imm_s : w_imm_i);
    assign w_idx    = w_addr[c_AW+1:2];
    assign w_unused = &{1'b0, w_addr[31:c_AW+2]};

    // ADDI ignores bit 30; only SRAI and SUB/SRA use it as the alternate-op select.
    assign w_alu_b   = (w_op == c_OP_REG) ? w_b : w_imm_i;
    assign w_alu_alt = komut[30] & ((w_f3 == 3'b101) | ((w_op == c_OP_REG) & (w_f3 == 3'b000)));

    always_comb begin
        w_alu_y = 32'h0;
        case (w_f3)
            3'b000:  w_alu_y = w_alu_alt ? (w_a - w_alu_b) : (w_a + w_alu_b);
            3'b001:  w_alu_y = w_a << w_alu_b[4:0];
            3'b010:  w_alu_y = {31'h0, $signed(w_a) < $signed(w_alu_b)};
            3'b011:  w_alu_y = {31'h0, w_a < w_alu_b};
            3'b100:  w_alu_y = w_a ^ w_alu_b;
            3'b101:  w_alu_y = w_alu_alt ? 32'($signed(w_a) >>> w_alu_b[4:0]) : (w_a >> w_alu_b[4:0]);
            3'b110:  w_alu_y = w_a | w_alu_b;
            default: w_alu_y = w_a & w_alu_b;
        endcase
    end

    always_comb begin
        w_legal   = 1'b0;
        w_wb      = 1'b0;
        w_store   = 1'b0;
        w_mem     = 1'b0;
        w_take    = 1'b0;
        w_wdata   = w_alu_y;
        w_next_pc = r_pc + 32'd4;
        case (w_op)
            c_OP_LUI: begin
                w_legal = 1'b1;
                w_wb    = 1'b1;
                w_wdata = w_imm_u;
            end
            c_OP_AUIPC: begin
                w_legal = 1'b1;
                w_wb    = 1'b1;
                w_wdata = r_pc + w_imm_u;
            end
            c_OP_JAL: begin
                w_legal   = 1'b1;
                w_wb      = 1'b1;
                w_wdata   = r_pc + 32'd4;
                w_next_pc = r_pc + w_imm_j;
            end
            c_OP_JALR: begin
                w_legal   = (w_f3 == 3'b000);
                w_wb      = 1'b1;
                w_wdata   = r_pc + 32'd4;
                w_next_pc = (w_a + w_imm_i) & ~32'd1;
            end
            c_OP_BRANCH: begin
                w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                case (w_f3)
                    3'b000:  w_take = (w_a == w_b);
                    3'b001:  w_take = (w_a != w_b);
                    3'b100:  w_take = ($signed(w_a) < $signed(w_b));
                    3'b101:  w_take = ($signed(w_a) >= $signed(w_b));
                    3'b110:  w_take = (w_a < w_b);
                    3'b111:  w_take = (w_a >= w_b);
                    default: w_take = 1'b0;
                endcase
                if (w_take) w_next_pc = r_pc + w_imm_b;
            end
            c_OP_LOAD: begin
                w_legal = (w_f3 == 3'b010);
                w_wb    = 1'b1;
                w_mem   = 1'b1;
                w_wdata = r_dmem[w_idx];
            end
            c_OP_STORE: begin
                w_legal = (w_f3 == 3'b010);
                w_store = 1'b1;
                w_mem   = 1'b1;
            end
            c_OP_IMM: begin
                w_wb = 1'b1;
                case (w_f3)
                    3'b001:  w_legal = (w_f7 == 7'b0000000);
                    3'b101:  w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    default: w_legal = 1'b1;
                endcase
            end
            c_OP_REG: begin
                w_wb = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    w_legal = 1'b1;
                end else if (w_f7 == 7'b0100000) begin
                    w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b101);
`ifdef GENC_MUL_EN
                end else if ((w_f7 == 7'b0000001) && (w_f3 == 3'b000)) begin
                    w_legal = 1'b1;
                    w_wdata = w_a * w_b;
`endif
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_err    = !w_legal || (w_mem && (w_addr[1:0] != 2'b00)) || (w_next_pc[1:0] != 2'b00);
    assign w_commit = !r_hata && !w_err;
    assign w_we_reg = w_commit && w_wb && (w_rd != 5'd0);
    assign w_we_mem = w_commit && w_store;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc   <= RESET_PC;
            r_hata <= 1'b0;
        end else if (!r_hata) begin
            if (w_err) r_hata <= 1'b1;
            else       r_pc   <= w_next_pc;
        end
    end

    for (genvar gi = 0; gi < 32; gi++) begin : g_regs
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)                              r_regs[gi] <= 32'h0;
            else if (w_we_reg && (w_rd == 5'(gi)))   r_regs[gi] <= w_wdata;
        end
    end

    for (genvar gm = 0; gm < DMEM_WORDS; gm++) begin : g_dmem
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)                               r_dmem[gm] <= 32'h0;
            else if (w_we_mem && (w_idx == c_AW'(gm))) r_dmem[gm] <= w_b;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_genc.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_genc                                                          |
// | Directed and random instruction checks of genc against an ISA model.       |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_genc;
    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] komut = 32'h0;
    logic [31:0] pc;
    logic        hata;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [64];
    logic [31:0] m_pc;
    logic        m_hata;
    logic [31:0] imem   [256];

    genc #(.RESET_PC(32'h0), .DMEM_WORDS(64)) dut (
        .clk(clk), .reset(reset), .komut(komut), .pc(pc), .hata(hata)
    );

    always #12 clk = ~clk;

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [31:0] v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_hata = 1'b0;
        foreach (m_regs[i]) m_regs[i] = 32'h0;
        foreach (m_mem[i])  m_mem[i]  = 32'h0;
    endtask

    // Architectural reference: one instruction's effect on the model state.
    task automatic model_step(input logic [31:0] k);
        logic [6:0]  op = k[6:0];
        logic [2:0]  f3 = k[14:12];
        logic [6:0]  f7 = k[31:25];
        int          rd = int'(k[11:7]);
        logic [31:0] a  = m_regs[k[19:15]];
        logic [31:0] b  = m_regs[k[24:20]];
        logic [31:0] ii = {{20{k[31]}}, k[31:20]};
        logic [31:0] is = {{20{k[31]}}, k[31:25], k[11:7]};
        logic [31:0] ib = {{19{k[31]}}, k[31], k[7], k[30:25], k[11:8], 1'b0};
        logic [31:0] ij = {{11{k[31]}}, k[31], k[19:12], k[20], k[30:21], 1'b0};
        logic [31:0] res = 0, npc = m_pc + 4, addr = 0;
        bit legal = 1, wr = 0, st = 0, mem = 0;
        if (m_hata) return;
        case (op)
            7'b0110111: begin wr = 1; res = {k[31:12], 12'h0}; end
            7'b0010111: begin wr = 1; res = m_pc + {k[31:12], 12'h0}; end
            7'b1101111: begin wr = 1; res = m_pc + 4; npc = m_pc + ij; end
            7'b1100111: begin legal = (f3 == 0); wr = 1; res = m_pc + 4; npc = (a + ii) & 32'hFFFF_FFFE; end
            7'b1100011: begin
                bit t = 0;
                case (f3)
                    0: t = (a == b);
                    1: t = (a != b);
                    4: t = ($signed(a) < $signed(b));
                    5: t = ($signed(a) >= $signed(b));
                    6: t = (a < b);
                    7: t = (a >= b);
                    default: legal = 0;
                endcase
                if (t) npc = m_pc + ib;
            end
            7'b0000011: begin legal = (f3 == 2); addr = a + ii; mem = 1; wr = 1; res = m_mem[(addr >> 2) % 64]; end
            7'b0100011: begin legal = (f3 == 2); addr = a + is; mem = 1; st = 1; end
            7'b0010011: begin
                wr = 1;
                case (f3)
                    0: res = a + ii;
                    2: res = ($signed(a) < $signed(ii)) ? 1 : 0;
                    3: res = (a < ii) ? 1 : 0;
                    4: res = a ^ ii;
                    6: res = a | ii;
                    7: res = a & ii;
                    1: begin legal = (f7 == 0); res = a << k[24:20]; end
                    default: begin
                        if (f7 == 0)          res = a >> k[24:20];
                        else if (f7 == 7'h20) res = 32'($signed(a) >>> k[24:20]);
                        else                  legal = 0;
                    end
                endcase
            end
            7'b0110011: begin
                wr = 1;
                if (f7 == 0) begin
                    case (f3)
                        0: res = a + b;
                        1: res = a << b[4:0];
                        2: res = ($signed(a) < $signed(b)) ? 1 : 0;
                        3: res = (a < b) ? 1 : 0;
                        4: res = a ^ b;
                        5: res = a >> b[4:0];
                        6: res = a | b;
                        default: res = a & b;
                    endcase
                end else if (f7 == 7'h20 && f3 == 0) res = a - b;
                else if (f7 == 7'h20 && f3 == 5)     res = 32'($signed(a) >>> b[4:0]);
`ifdef GENC_MUL_EN
                else if (f7 == 1 && f3 == 0)         res = 32'(64'(a) * 64'(b));
`endif
                else legal = 0;
            end
            default: legal = 0;
        endcase
        if (!legal || (mem && addr[1:0] != 0) || npc[1:0] != 0) begin
            m_hata = 1;
        end else begin
            if (wr && rd != 0) m_regs[rd] = res;
            if (st) m_mem[(addr >> 2) % 64] = b;
            m_pc = npc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_pc", pc, 32'h0);
        chk("rst_hata", {31'h0, hata}, 32'h0);
        #9;
        reset = 1'b1;
    endtask

    task automatic step(input logic [31:0] k);
        komut = k;
        @(posedge clk);
        model_step(k);
        #1;
        chk("pc", pc, m_pc);
        chk("hata", {31'h0, hata}, {31'h0, m_hata});
    endtask

    task automatic run_prog(input int n);
        for (int i = 0; i < n; i++) step(imem[pc[9:2]]);
    endtask

    task automatic clear_imem();
        foreach (imem[i]) imem[i] = enc_j(0, 0);
    endtask

    task automatic cmp_state();
        for (int i = 0; i < 32; i++) chk($sformatf("x%0d", i), dut.r_regs[i], m_regs[i]);
        for (int i = 0; i < 64; i++) chk($sformatf("mem%0d", i), dut.r_dmem[i], m_mem[i]);
    endtask

    function automatic int rimm(input int span);
        int v = (int'($urandom_range(0, 2 * span)) - span) * 4;
        if ($urandom_range(0, 7) == 0) v += 2;
        return v;
    endfunction

    function automatic logic [31:0] gen_rand();
        int r   = int'($urandom_range(0, 99));
        int rd  = int'($urandom_range(0, 7));
        int rs1 = int'($urandom_range(0, 7));
        int rs2 = int'($urandom_range(0, 7));
        int f3  = int'($urandom_range(0, 7));
        logic [31:0] u = $urandom();
        if (r < 8)  return {u[31:12], 5'(rd), 7'b0110111};
        if (r < 12) return {u[31:12], 5'(rd), 7'b0010111};
        if (r < 38) begin
            int imm = int'(u[11:0]);
            if (f3 == 1) imm = int'(u[4:0]);
            if (f3 == 5) imm = int'(u[4:0]) + (u[20] ? 32'h400 : 0);
            return enc_i(imm, rs1, f3, rd, 7'b0010011);
        end
        if (r < 60) begin
            int f7 = 0;
            if ((f3 == 0 || f3 == 5) && u[0]) f7 = 32;
            if ($urandom_range(0, 9) == 0) begin f7 = 1; f3 = 0; end
            return enc_r(f7, rs2, rs1, f3, rd);
        end
        if (r < 76) begin
            int imm = int'($urandom_range(0, 255)) * 4;
            if ($urandom_range(0, 7) == 0) imm += 1;
            if ($urandom_range(0, 3) != 0) rs1 = 0;
            if (r < 68) return enc_i(imm, rs1, 2, rd, 7'b0000011);
            return enc_s(imm, rs2, rs1);
        end
        if (r < 86) begin
            case ($urandom_range(0, 5))
                0: f3 = 0; 1: f3 = 1; 2: f3 = 4; 3: f3 = 5; 4: f3 = 6; default: f3 = 7;
            endcase
            return enc_b(rimm(8), rs2, rs1, f3);
        end
        if (r < 90) return enc_j(rimm(8), rd);
        if (r < 95) return enc_i(int'($urandom_range(0, 63)) * 4, ($urandom_range(0, 3) == 0) ? rs1 : 0, 0, rd, 7'b1100111);
        return u[0] ? 32'h0 : $urandom();
    endfunction

    initial begin
        model_reset();

        // Reset, then one ADDI on the first edge.
        clear_imem();
        imem[0] = enc_i(5, 0, 0, 1, 7'b0010011);
        do_reset();
        run_prog(1);
        chk("addi_x1", dut.r_regs[1], 32'd5);
        chk("addi_pc", pc, 32'd4);

        // BEQ / BNE with equal operands at pc=8.
        imem[1] = enc_i(5, 0, 0, 2, 7'b0010011);
        imem[2] = enc_b(8, 2, 1, 0);
        do_reset();
        run_prog(3);
        chk("beq_pc", pc, 32'd16);
        imem[2] = enc_b(8, 2, 1, 1);
        do_reset();
        run_prog(3);
        chk("bne_pc", pc, 32'd12);

        // All-zero instruction at pc=20 halts the core.
        clear_imem();
        for (int i = 0; i < 5; i++) imem[i] = enc_i(10 + i, 0, 0, i + 1, 7'b0010011);
        imem[5] = 32'h0;
        do_reset();
        run_prog(6);
        chk("ill_hata", {31'h0, hata}, 32'd1);
        chk("ill_pc", pc, 32'd20);
        step(enc_i(77, 0, 0, 6, 7'b0010011));
        step(enc_i(77, 0, 0, 1, 7'b0010011));
        chk("halt_pc", pc, 32'd20);
        chk("halt_x6", dut.r_regs[6], 32'd0);
        chk("halt_x1", dut.r_regs[1], 32'd10);
        do_reset();

        // Misaligned store, then wrap-around load.
        clear_imem();
        imem[0] = enc_i(123, 0, 0, 1, 7'b0010011);
        imem[1] = enc_s(2, 1, 0);
        do_reset();
        run_prog(2);
        chk("sw_mis_hata", {31'h0, hata}, 32'd1);
        chk("sw_mis_mem", dut.r_dmem[0], 32'd0);
        imem[1] = enc_s(0, 1, 0);
        imem[2] = enc_i(256, 0, 2, 5, 7'b0000011);
        do_reset();
        run_prog(3);
        chk("lw_wrap_x5", dut.r_regs[5], 32'd123);
        chk("lw_wrap_hata", {31'h0, hata}, 32'd0);

        // MUL encoding.
        clear_imem();
        imem[0] = enc_i(7, 0, 0, 1, 7'b0010011);
        imem[1] = enc_i(6, 0, 0, 2, 7'b0010011);
        imem[2] = enc_i(99, 0, 0, 3, 7'b0010011);
        imem[3] = enc_r(1, 2, 1, 0, 3);
        do_reset();
        run_prog(4);
`ifdef GENC_MUL_EN
        chk("mul_x3", dut.r_regs[3], 32'd42);
        chk("mul_hata", {31'h0, hata}, 32'd0);
`else
        chk("mul_x3", dut.r_regs[3], 32'd99);
        chk("mul_hata", {31'h0, hata}, 32'd1);
`endif

        // Iterative Fibonacci F(20), result stored to word 4.
        clear_imem();
        imem[0]  = enc_i(0, 0, 0, 1, 7'b0010011);
        imem[1]  = enc_i(1, 0, 0, 2, 7'b0010011);
        imem[2]  = enc_i(20, 0, 0, 3, 7'b0010011);
        imem[3]  = enc_b(24, 0, 3, 0);
        imem[4]  = enc_r(0, 2, 1, 0, 4);
        imem[5]  = enc_i(0, 2, 0, 1, 7'b0010011);
        imem[6]  = enc_i(0, 4, 0, 2, 7'b0010011);
        imem[7]  = enc_i(-1, 3, 0, 3, 7'b0010011);
        imem[8]  = enc_j(-20, 0);
        imem[9]  = enc_s(16, 1, 0);
        imem[10] = enc_j(0, 0);
        do_reset();
        run_prog(416);
        chk("fib_x1", dut.r_regs[1], 32'd6765);
        chk("fib_mem", dut.r_dmem[4], 32'd6765);
        chk("fib_hata", {31'h0, hata}, 32'd0);
        cmp_state();

        // Random instruction bursts, with occasional asynchronous reset mid-cycle.
        for (int b = 0; b < 14; b++) begin
            do_reset();
            for (int s = 0; s < 120 && !m_hata; s++) begin
                if ($urandom_range(0, 59) == 0) begin
                    @(negedge clk);
                    reset = 1'b0;
                    #1;
                    model_reset();
                    chk("mid_rst_pc", pc, 32'h0);
                    chk("mid_rst_hata", {31'h0, hata}, 32'h0);
                    #5;
                    reset = 1'b1;
                end
                step(gen_rand());
            end
            step(gen_rand());
            step(gen_rand());
            cmp_state();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
